// File: rtl/flag_branch_unit.sv
// Architectural z/v/n flag register, in-flight flag-writer tracking and
// conditional-branch resolution with same-cycle flag forwarding.
module flag_branch_unit #(
    parameter int unsigned PEND_W = 2,
    parameter int unsigned PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pend_inc,
    input  logic              flag_we,
    input  logic              z_in,
    input  logic              v_in,
    input  logic              n_in,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [PC_W-1:0]   br_pc,
    input  logic [PC_W-1:0]   br_off,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [PC_W-1:0]   res_target,
    output logic              z,
    output logic              v,
    output logic              n,
    output logic              pend_err
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PEND_W-1:0]   pend_cnt;
    logic [PEND_W-1:0]   pend_d;
    logic                err_set_c;
    logic [2:0]          cond_q;
    logic [PC_W-1:0]     target_q;
    logic                capture_c;
    logic                eval_c;
    logic                final_c;
    logic                eff_z_c;
    logic                eff_v_c;
    logic                eff_n_c;
    logic [2:0]          sel_cond_c;
    logic [PC_W-1:0]     sel_target_c;
    logic [PC_W-1:0]     sum_c;

    function automatic logic cond_eval(input logic [2:0] c, input logic fz,
                                       input logic fv, input logic fn);
        logic lt;
        lt = fn ^ fv;
        case (c)
            3'b000:  cond_eval = fz;
            3'b001:  cond_eval = ~fz;
            3'b010:  cond_eval = lt;
            3'b011:  cond_eval = ~lt;
            3'b100:  cond_eval = fz | lt;
            3'b101:  cond_eval = ~fz & ~lt;
            3'b110:  cond_eval = 1'b1;
            default: cond_eval = fv;
        endcase
    endfunction

    // Pending flag-writer bookkeeping; saturating at both ends flags misuse.
    always_comb begin
        pend_d    = pend_cnt;
        err_set_c = 1'b0;
        if (pend_inc && !flag_we) begin
            if (pend_cnt == PEND_MAX) err_set_c = 1'b1;
            else                      pend_d    = pend_cnt + PEND_ONE;
        end else if (flag_we && !pend_inc) begin
            if (pend_cnt == '0) err_set_c = 1'b1;
            else                pend_d    = pend_cnt - PEND_ONE;
        end
    end

    // Flags are final once the last outstanding writer lands this cycle.
    always_comb begin
        final_c = (pend_cnt == '0) ||
                  ((pend_cnt == PEND_ONE) && flag_we && !pend_inc);
        eff_z_c = flag_we ? z_in : z;
        eff_v_c = flag_we ? v_in : v;
        eff_n_c = flag_we ? n_in : n;
        sum_c   = br_pc + br_off;
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        capture_c = 1'b0;
        eval_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (br_valid) begin
                    capture_c = 1'b1;
                    if (final_c) begin
                        eval_c  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (final_c) begin
                    eval_c  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Evaluate against the live request when resolving in the accept cycle.
    always_comb begin
        sel_cond_c   = capture_c ? br_cond : cond_q;
        sel_target_c = capture_c ? sum_c   : target_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_cnt   <= '0;
            pend_err   <= 1'b0;
            z          <= 1'b0;
            v          <= 1'b0;
            n          <= 1'b0;
            cond_q     <= 3'b000;
            target_q   <= '0;
            res_taken  <= 1'b0;
            res_target <= '0;
            res_valid  <= 1'b0;
            br_ready   <= 1'b1;
        end else begin
            state_q  <= state_d;
            pend_cnt <= pend_d;
            if (err_set_c) pend_err <= 1'b1;
            if (flag_we) begin
                z <= z_in;
                v <= v_in;
                n <= n_in;
            end
            if (capture_c) begin
                cond_q   <= br_cond;
                target_q <= sum_c;
            end
            if (eval_c) begin
                res_taken  <= cond_eval(sel_cond_c, eff_z_c, eff_v_c, eff_n_c);
                res_target <= sel_target_c;
            end
            res_valid <= (state_d == HOLD);
            br_ready  <= (state_d == IDLE);
        end
    end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumes the z/v/n condition flags produced by the 16-bit ALU and holds them in an architectural flag register.
- Resolves conditional branches against those flags.
- Tracks in-flight flag-writing instructions and stalls a branch until its flags are final. Same-cycle flag writes are forwarded.
- Sits between decode (branch issue) and fetch (redirect), downstream of the ALU flag outputs.

Parameters:
PEND_W, 2, width of the in-flight flag-writer counter (max outstanding = 2^PEND_W - 1)
PC_W, 16, width of PC, offset and target

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
pend_inc  in  1  a flag-writing instruction issued this cycle
flag_we  in  1  ALU flag writeback this cycle (retires one pending writer)
z_in  in  1  ALU zero flag
v_in  in  1  ALU overflow flag
n_in  in  1  ALU negative flag
br_valid  in  1  branch request valid
br_ready  out  1  unit can accept a branch
br_cond  in  3  condition code
br_pc  in  PC_W  branch instruction PC
br_off  in  PC_W  signed offset
res_valid  out  1  resolution valid
res_ready  in  1  fetch accepts resolution
res_taken  out  1  branch taken
res_target  out  PC_W  redirect PC
z  out  1  architectural zero flag
v  out  1  architectural overflow flag
n  out  1  architectural negative flag
pend_err  out  1  sticky: pend_inc while counter full, or flag_we while counter zero

Behaviour:
- Reset is synchronous and active-low: the single clock clk and reset rst_n; all state updates on the rising edge of clk, with rst_n=0 sampled there.
- Reset values: z=v=n=0, pend_cnt=0, state=IDLE, br_ready=1, res_valid=0, res_taken=0, res_target=0, pend_err=0. A reset mid-wait or mid-hold discards the captured branch.
- Flag register: on flag_we, {z,v,n} <= {z_in,v_in,n_in}. Otherwise the register holds.
- Pending counter, updated each cycle:
  - pend_inc and flag_we together: count unchanged.
  - pend_inc alone: count +1. If the counter is full, the count stays unchanged and pend_err is set.
  - flag_we alone: count -1. If the counter is 0, the count stays at 0 and pend_err is set.
  - pend_err clears only on reset.
- Effective flags (eff) for evaluation: {z_in,v_in,n_in} when flag_we=1 in that cycle, else the registered flags.
- "Flags final" condition: pend_cnt==0, or (pend_cnt==1 and flag_we=1 and pend_inc=0).
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: br_ready=1. On br_valid, capture cond/pc/off.
    - If flags final: evaluate with eff, go to HOLD.
    - Otherwise go to WAIT.
  - WAIT: br_ready=0. Each cycle, test the flags-final condition. When it holds, evaluate with eff and go to HOLD.
  - HOLD: res_valid=1; res_taken and res_target are stable until res_ready. On res_ready, go to IDLE; res_valid drops next cycle. No back-to-back accept in the same cycle.
- Minimum latency: br_valid accepted at cycle t gives res_valid high at t+1.
- Condition codes (T=taken):
  - 000 EQ: z
  - 001 NE: ~z
  - 010 LT: n^v
  - 011 GE: ~(n^v)
  - 100 LE: z|(n^v)
  - 101 GT: ~z&~(n^v)
  - 110 AL: 1
  - 111 VS: v
- Target: res_target = br_pc + br_off, modulo 2^PC_W. Wrap-around is silent. It is computed even when not taken; fetch uses it only when res_taken=1.
- Flag writes and pend_inc continue to update the register and counter in every state. A result held in HOLD is never re-evaluated.

Test Plan:
1. Reset, then flag_we with z_in=1,v_in=0,n_in=0; next cycle br_valid, cond=000, pc=0x0010, off=0x0008 -> res_valid after 1 cycle, res_taken=1, res_target=0x0018; z=1.
2. pend_inc at t0, branch cond=010 at t1 (WAIT, br_ready=0); flag_we with n_in=1,v_in=0 at t3 -> res_valid at t4, res_taken=1.
3. pend_cnt=1, branch cond=011 arrives in the same cycle as flag_we with n_in=1,v_in=1 (forwarding) -> res_valid next cycle, res_taken=1, no WAIT cycle.
4. pc=0xFFFC, off=0x0008, cond=110 -> res_target=0x0004, res_taken=1; hold res_ready=0 for 3 cycles -> outputs stable, br_ready=0.
5. Issue 4 pend_inc with PEND_W=2 -> count saturates at 3, pend_err=1; 3 flag_we -> count 0; further flag_we -> pend_err stays 1, count 0.
6. Assert rst_n=0 while in WAIT -> next cycle state=IDLE, res_valid=0, pend_cnt=0, flags 0, pend_err=0.
